// File: rtl/move_sequencer_if.sv
// Request/pulse bundle between the command source and the move sequencer.
interface move_sequencer_if;
    logic       req_fwd;
    logic       req_rev;
    logic       req_stop;
    logic       req_auto;
    logic [7:0] auto_cycles;
    logic       start;
    logic       start_N;
    logic       stop;
    logic       avto;
    logic       busy;
    logic       dir;
    logic       auto_on;
    logic       done;
    logic       err;

    modport master (
        output req_fwd, req_rev, req_stop, req_auto, auto_cycles,
        input  start, start_N, stop, avto, busy, dir, auto_on, done, err
    );

    modport slave (
        input  req_fwd, req_rev, req_stop, req_auto, auto_cycles,
        output start, start_N, stop, avto, busy, dir, auto_on, done, err
    );
endinterface

// File: rtl/move_sequencer.sv
// Command sequencer for the TR_P drive: merges manual and auto requests into
// registered start/start_N/stop/avto pulses with a stop-then-dwell interlock.
module move_sequencer #(
    parameter int unsigned RUN_CYC   = 500000,
    parameter int unsigned DWELL_CYC = 50000,
    parameter int unsigned CNT_W     = 20
) (
    input logic            clk,
    input logic            rst,
    move_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN_F, RUN_R, DWELL} state_t;
    typedef enum logic [1:0] {PEND_NONE, PEND_F, PEND_R} pend_t;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    state_t           state, state_n;
    pend_t            pend, pend_n;
    logic [7:0]       cyc_left, cyc_left_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             auto_q, auto_n;
    logic             dir_q, dir_d;
    logic             start_q, start_n_q, stop_q, avto_q, done_q, err_q;
    logic             start_d, start_n_d, stop_d, avto_d, done_d, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= PEND_NONE;
            cyc_left  <= '0;
            cnt       <= '0;
            auto_q    <= 1'b0;
            dir_q     <= 1'b0;
            start_q   <= 1'b0;
            start_n_q <= 1'b0;
            stop_q    <= 1'b0;
            avto_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            cyc_left  <= cyc_left_n;
            cnt       <= cnt_n;
            auto_q    <= auto_n;
            dir_q     <= dir_d;
            start_q   <= start_d;
            start_n_q <= start_n_d;
            stop_q    <= stop_d;
            avto_q    <= avto_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_n    = state;
        pend_n     = pend;
        cyc_left_n = cyc_left;
        auto_n     = auto_q;
        unique case (state)
            IDLE: begin
                if (!bus.req_stop) begin
                    if (bus.req_auto) begin
                        if (bus.auto_cycles != '0) begin
                            state_n    = RUN_F;
                            auto_n     = 1'b1;
                            cyc_left_n = bus.auto_cycles;
                            pend_n     = PEND_NONE;
                        end
                    end else if (bus.req_fwd) begin
                        state_n = RUN_F;
                    end else if (bus.req_rev) begin
                        state_n = RUN_R;
                    end
                end
            end
            RUN_F, RUN_R: begin
                if (bus.req_stop) begin
                    state_n = DWELL;
                    pend_n  = PEND_NONE;
                    auto_n  = 1'b0;
                end else if (auto_q) begin
                    if (cnt == RUN_LAST) begin
                        state_n = DWELL;
                        if (state == RUN_F) begin
                            pend_n = PEND_R;
                        end else begin
                            cyc_left_n = cyc_left - 8'd1;
                            pend_n     = (cyc_left == 8'd1) ? PEND_NONE : PEND_F;
                        end
                    end
                end else if (state == RUN_F && bus.req_rev) begin
                    state_n = DWELL;
                    pend_n  = PEND_R;
                end else if (state == RUN_R && bus.req_fwd) begin
                    state_n = DWELL;
                    pend_n  = PEND_F;
                end
            end
            DWELL: begin
                if (bus.req_stop) begin
                    pend_n = PEND_NONE;
                    auto_n = 1'b0;
                end else if (!auto_q) begin
                    if (bus.req_fwd)      pend_n = PEND_F;
                    else if (bus.req_rev) pend_n = PEND_R;
                end
                // A request on the expiry cycle itself still steers the exit.
                if (cnt == DWELL_LAST) begin
                    unique case (pend_n)
                        PEND_F:  state_n = RUN_F;
                        PEND_R:  state_n = RUN_R;
                        default: begin
                            state_n = IDLE;
                            auto_n  = 1'b0;
                        end
                    endcase
                    pend_n = PEND_NONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state)
            cnt_n = '0;
        else if (state == DWELL || auto_q)
            cnt_n = cnt + CNT_W'(1);
        else
            cnt_n = cnt;
    end

    // Pulses are decoded from the transition about to be registered.
    always_comb begin
        start_d   = (state_n == RUN_F) && (state != RUN_F);
        start_n_d = (state_n == RUN_R) && (state != RUN_R);
        stop_d    = ((state == RUN_F || state == RUN_R) && state_n == DWELL) ||
                    (state == IDLE && bus.req_stop);
        avto_d    = (state == IDLE) && (state_n == RUN_F) && auto_n;
        done_d    = (state == DWELL) && (state_n == IDLE) && auto_q && !bus.req_stop;
        err_d     = (state == IDLE) && !bus.req_stop && bus.req_auto &&
                    (bus.auto_cycles == '0);
        dir_d     = start_n_d ? 1'b1 : (start_d ? 1'b0 : dir_q);
    end

    assign bus.start   = start_q;
    assign bus.start_N = start_n_q;
    assign bus.stop    = stop_q;
    assign bus.avto    = avto_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.dir     = dir_q;
    assign bus.auto_on = auto_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus random
// requests against an event-schedule reference model.
module tb_move_sequencer;
    localparam int R   = 20;
    localparam int D   = 10;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_sequencer_if bus ();

    move_sequencer #(.RUN_CYC(R), .DWELL_CYC(D), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected pulses keyed by cycle: bit0 start, 1 start_N, 2 stop, 3 avto, 4 done, 5 err.
    bit [5:0] ev[int];
    int idle_at  = 0;
    int auto_end = 0;
    int epoch    = 0;

    function automatic bit [5:0] ev_at(int c);
        return ev.exists(c) ? ev[c] : 6'd0;
    endfunction

    function automatic void add_ev(int c, int b);
        bit [5:0] v;
        v    = ev_at(c);
        v[b] = 1'b1;
        ev[c] = v;
    endfunction

    function automatic void clear_starts(int c);
        if (ev.exists(c)) ev[c] = ev[c] & 6'b111100;
    endfunction

    function automatic void drop_after(int s);
        int keys[$];
        foreach (ev[k]) if (k > s) keys.push_back(k);
        foreach (keys[i]) ev.delete(keys[i]);
    endfunction

    // Most recent start/start_N/stop at or before cycle c: 0,1,2 or -1.
    function automatic int last_motion(int c, output int t);
        for (int k = c; k >= epoch; k--) begin
            bit [5:0] v;
            v = ev_at(k);
            t = k;
            if (v[2]) return 2;
            if (v[1]) return 1;
            if (v[0]) return 0;
        end
        t = -1;
        return -1;
    endfunction

    function automatic bit dir_at(int c);
        for (int k = c; k >= epoch; k--) begin
            bit [5:0] v;
            v = ev_at(k);
            if (v[1]) return 1'b1;
            if (v[0]) return 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic void model_edge(int s, bit rs, bit f, bit r, bit st, bit a, int n);
        int kind, tm, base, c0, e;
        if (rs) begin
            ev.delete();
            idle_at  = 0;
            auto_end = 0;
            epoch    = s + 1;
            return;
        end
        if (s >= idle_at) begin
            if (st) add_ev(s + 1, 2);
            else if (a) begin
                if (n != 0) begin
                    base = s + 1;
                    add_ev(base, 3);
                    for (int k = 0; k < n; k++) begin
                        c0 = base + k * 2 * (R + D);
                        add_ev(c0, 0);
                        add_ev(c0 + R, 2);
                        add_ev(c0 + R + D, 1);
                        add_ev(c0 + 2 * R + D, 2);
                    end
                    idle_at  = base + n * 2 * (R + D);
                    auto_end = idle_at;
                    add_ev(idle_at, 4);
                end else add_ev(s + 1, 5);
            end else if (f) begin
                add_ev(s + 1, 0);
                idle_at = INF;
            end else if (r) begin
                add_ev(s + 1, 1);
                idle_at = INF;
            end
            return;
        end
        kind = last_motion(s, tm);
        if (s < auto_end) begin
            if (st) begin
                drop_after(s);
                auto_end = s + 1;
                if (kind == 2) idle_at = tm + D;
                else begin
                    add_ev(s + 1, 2);
                    idle_at = s + 1 + D;
                end
            end
        end else if (kind == 2) begin
            e = tm + D;
            if (st) begin
                clear_starts(e);
                idle_at = e;
            end else if (f || r) begin
                clear_starts(e);
                add_ev(e, f ? 0 : 1);
                idle_at = INF;
            end
        end else begin
            if (st) begin
                add_ev(s + 1, 2);
                idle_at = s + 1 + D;
            end else if ((kind == 0 && r) || (kind == 1 && f)) begin
                add_ev(s + 1, 2);
                add_ev(s + 1 + D, kind == 0 ? 1 : 0);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        bit [5:0]  v;
        logic [8:0] obs, exp;
        v   = ev_at(cyc);
        exp = {v[0], v[1], v[2], v[3], v[4], v[5], 1'(cyc < idle_at), dir_at(cyc),
               1'(cyc < auto_end)};
        obs = {bus.start, bus.start_N, bus.stop, bus.avto, bus.done, bus.err,
               bus.busy, bus.dir, bus.auto_on};
        chk("outputs", 16'(obs), 16'(exp));
        chk("one_motion_pulse",
            16'(($countones({bus.start, bus.start_N, bus.stop}) <= 1) ? 1 : 0), 16'd1);
    endtask

    task automatic tick(input bit f = 0, input bit r = 0, input bit st = 0,
                        input bit a = 0, input int n = 0, input bit rs = 0);
        bus.req_fwd     = f;
        bus.req_rev     = r;
        bus.req_stop    = st;
        bus.req_auto    = a;
        bus.auto_cycles = 8'(n);
        rst             = rs;
        @(posedge clk);
        model_edge(cyc, rs, f, r, st, a, n);
        cyc++;
        #1;
        check_cycle();
        bus.req_fwd  = 1'b0;
        bus.req_rev  = 1'b0;
        bus.req_stop = 1'b0;
        bus.req_auto = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    initial begin
        int pick;
        bus.req_fwd     = 1'b0;
        bus.req_rev     = 1'b0;
        bus.req_stop    = 1'b0;
        bus.req_auto    = 1'b0;
        bus.auto_cycles = 8'd0;

        // Reset, then a manual forward start.
        repeat (5) tick(.rs(1));
        chk("reset_outputs", 16'({bus.start, bus.start_N, bus.stop, bus.avto, bus.busy,
                                  bus.dir, bus.auto_on, bus.done, bus.err}), 16'd0);
        idle(1);
        tick(.f(1));
        chk("fwd_start", 16'(bus.start), 16'd1);
        chk("fwd_busy", 16'(bus.busy), 16'd1);
        chk("fwd_dir", 16'(bus.dir), 16'd0);

        // Reversal through the dwell interlock.
        idle(3);
        tick(.r(1));
        chk("rev_stop", 16'(bus.stop), 16'd1);
        idle(9);
        tick();
        chk("rev_start_N", 16'(bus.start_N), 16'd1);
        chk("rev_dir", 16'(bus.dir), 16'd1);
        tick(.st(1));
        idle(12);

        // Two-cycle auto run; done lands 120 cycles after avto.
        tick(.a(1), .n(2));
        chk("auto_avto_start", 16'({bus.avto, bus.start}), 16'b11);
        repeat (120) tick();
        chk("auto_done", 16'(bus.done), 16'd1);
        chk("auto_done_idle", 16'(bus.busy), 16'd0);
        idle(3);

        // Abort while auto is running reverse.
        tick(.a(1), .n(1));
        idle(35);
        chk("abort_in_rev", 16'(bus.dir), 16'd1);
        tick(.st(1));
        chk("abort_stop", 16'(bus.stop), 16'd1);
        chk("abort_auto_off", 16'(bus.auto_on), 16'd0);
        idle(15);
        chk("abort_idle", 16'(bus.busy), 16'd0);

        // Stop outranks forward; zero-cycle auto flags an error.
        tick(.f(1));
        idle(3);
        tick(.st(1), .f(1));
        chk("prio_stop_only", 16'({bus.start, bus.start_N, bus.stop}), 16'b001);
        idle(11);
        chk("prio_idle", 16'(bus.busy), 16'd0);
        tick(.a(1), .n(0));
        chk("auto_zero_err", 16'(bus.err), 16'd1);
        chk("auto_zero_idle", 16'(bus.busy), 16'd0);

        // Reset during a dwell with reverse pending.
        tick(.f(1));
        idle(2);
        tick(.r(1));
        idle(3);
        tick(.rs(1));
        chk("rst_dwell_outputs", 16'({bus.start, bus.start_N, bus.stop, bus.busy,
                                      bus.dir, bus.auto_on}), 16'd0);
        idle(15);

        // Random single requests and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            pick = int'($urandom_range(0, 999));
            if (pick < 30)       tick(.f(1));
            else if (pick < 60)  tick(.r(1));
            else if (pick < 80)  tick(.st(1));
            else if (pick < 92)  tick(.a(1), .n(int'($urandom_range(0, 3))));
            else if (pick < 95)  tick(.rs(1));
            else                 tick();
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
